// File: rtl/syncram_pkg.sv
// Shared types, constants and helpers for the syncram_pipe RAM.
package syncram_pkg;

  // Sweep state: CLEAR zeroes the array word by word, READY serves requests.
  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  // Supported read latencies (inclusive range).
  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Number of byte-offset address bits for a word of data_w bits.
  function automatic int unsigned off_width(input int unsigned data_w);
    return (data_w <= 8) ? 0 : $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/syncram_bemerge.sv
// Byte-enable merge: replaces each enabled byte of old_word with the din byte.
module syncram_bemerge #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   new_word
);

  // Per-byte select between the stored byte and the incoming byte.
  always_comb begin
    new_word = old_word;
    for (int unsigned k = 0; k < DATA_W / 8; k++) begin
      if (be[k]) new_word[8*k +: 8] = din[8*k +: 8];
    end
  end

endmodule

// File: rtl/syncram_pipe.sv
// Synchronous single-port RAM with byte enables, write-first reads,
// optional post-reset clear sweep, and 1- or 2-cycle reads.
module syncram_pipe
  import syncram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned READ_LAT       = 1,
  parameter string       MEM_FILE       = "",
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                oe,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                err
);

  localparam int unsigned OFF_W     = off_width(DATA_W);
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam bit          HAS_FILE  = (MEM_FILE != "");
  localparam bit          DO_CLEAR  = CLEAR_ON_RESET && !HAS_FILE;
  localparam state_t      RST_STATE = DO_CLEAR ? CLEAR : READY;

  if ((DATA_W % 8) != 0 || DATA_W < 8 ||
      READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_param_check
    $error("syncram_pipe: illegal DATA_W (%0d) or READ_LAT (%0d)", DATA_W, READ_LAT);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                clr_we;

  logic [ADDR_W-1:0]   idx;
  logic                in_range;
  logic                ready;
  logic                req;
  logic                wr_en;
  logic                rd_en;
  logic                err_now;
  logic [DATA_W/8-1:0] be_eff;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   new_word;

  logic [DATA_W-1:0]   d1;
  logic                v1;
  logic                e1;

  // Sweep state and counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: step through every word once, then stay in READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = RST_STATE;
    endcase
  end

  assign idx      = addr[OFF_W +: ADDR_W];
  assign in_range = ((addr >> (OFF_W + ADDR_W)) == '0);
  assign ready    = (state == READY);
  assign req      = cs & (oe | we);
  assign be_eff   = (cs && we) ? be : '0;
  assign old_word = mem[idx];
  assign wr_en    = ready & cs & we & in_range;
  assign rd_en    = ready & cs & oe;
  assign err_now  = req & (~ready | ~in_range);

  // new_word equals old_word unless this request writes, so the same
  // merge result serves both the array update and write-first forwarding.
  syncram_bemerge #(
    .DATA_W (DATA_W)
  ) u_bemerge (
    .old_word (old_word),
    .din      (din),
    .be       (be_eff),
    .new_word (new_word)
  );

  // Array update: clear sweep or byte-merged write; reset never touches it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we)     mem[cnt] <= '0;
      else if (wr_en) mem[idx] <= new_word;
    end
  end

  // First read stage: registered data, valid and error for this request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      e1 <= err_now;
      if (rd_en) d1 <= in_range ? new_word : '0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d2;
    logic              v2;
    logic              e2;

    // Second read stage: delays data, valid and error by one more edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2 <= '0;
        v2 <= 1'b0;
        e2 <= 1'b0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end

    assign dout       = d2;
    assign dout_valid = v2;
    assign err        = e2;
  end else begin : g_lat1
    assign dout       = d1;
    assign dout_valid = v1;
    assign err        = e1;
  end

endmodule

// File: tb/tb_syncram_pipe.sv
// Directed bench for syncram_pipe: one READ_LAT=1 and one READ_LAT=2 instance
// share stimulus; both use DATA_W=32, ADDR_W=4 and the clear sweep.
module tb_syncram_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        oe = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout1, dout2;
  logic        v1, v2, busy1, busy2, err1, err2;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  syncram_pipe #(
    .DATA_W         (32),
    .ADDR_W         (4),
    .READ_LAT       (1),
    .MEM_FILE       (""),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .oe         (oe),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .din        (din),
    .dout       (dout1),
    .dout_valid (v1),
    .busy       (busy1),
    .err        (err1)
  );

  syncram_pipe #(
    .DATA_W         (32),
    .ADDR_W         (4),
    .READ_LAT       (2),
    .MEM_FILE       (""),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .oe         (oe),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .din        (din),
    .dout       (dout2),
    .dout_valid (v2),
    .busy       (busy2),
    .err        (err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic o, input logic w,
                       input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    cs = c; oe = o; we = w; be = b; addr = a; din = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic issue(input logic c, input logic o, input logic w,
                       input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    drive(c, o, w, b, a, d);
    tick();
    idle();
  endtask

  task automatic count_busy(output int unsigned n);
    n = 0;
    while (busy1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  logic [31:0] pa [3];
  logic [31:0] pe [3];
  int unsigned n;

  initial begin
    pa[0] = 32'h00; pa[1] = 32'h04;       pa[2] = 32'h08;
    pe[0] = 32'h0;  pe[1] = 32'h0404CAFE; pe[2] = 32'hDEADBEAA;

    idle();
    #1;
    check("rst_busy", busy1, 1);
    check("rst_busy_lat2", busy2, 1);
    check("rst_dout", dout1, 0);
    check("rst_valid", v1, 0);
    check("rst_err", err1, 0);
    tick();
    tick();
    check("rst_busy_held", busy1, 1);

    rst_n = 1'b1;
    count_busy(n);
    check("sweep_len", n, 16);
    check("sweep_done_lat2", busy2, 0);

    issue(1, 1, 0, 4'h0, 32'h3C, 0);
    check("rd3c_valid", v1, 1);
    check("rd3c_dout", dout1, 32'h0);
    check("rd3c_err", err1, 0);
    check("rd3c_lat2_early", v2, 0);
    tick();
    check("rd3c_valid_pulse", v1, 0);
    check("rd3c_lat2_valid", v2, 1);
    check("rd3c_lat2_dout", dout2, 32'h0);

    issue(1, 0, 1, 4'hF, 32'h08, 32'hDEADBEEF);
    check("wr_no_valid", v1, 0);
    check("wr_no_err", err1, 0);
    issue(1, 0, 1, 4'h1, 32'h08, 32'h000000AA);
    issue(1, 1, 0, 4'h0, 32'h08, 0);
    check("be_merge", dout1, 32'hDEADBEAA);

    issue(1, 0, 1, 4'hF, 32'h10, 32'h11111111);
    issue(1, 1, 1, 4'hC, 32'h10, 32'h22222222);
    check("wf_valid", v1, 1);
    check("wf_dout", dout1, 32'h22221111);
    tick();
    check("dout_hold", dout1, 32'h22221111);
    check("dout_hold_valid", v1, 0);
    check("wf_lat2_dout", dout2, 32'h22221111);
    check("wf_lat2_valid", v2, 1);
    issue(1, 1, 0, 4'h0, 32'h10, 0);
    check("wf_readback", dout1, 32'h22221111);

    issue(1, 1, 0, 4'h0, 32'h40, 0);
    check("oor_rd_dout", dout1, 32'h0);
    check("oor_rd_valid", v1, 1);
    check("oor_rd_err", err1, 1);
    tick();
    check("oor_err_pulse", err1, 0);
    check("oor_lat2_err", err2, 1);
    check("oor_lat2_valid", v2, 1);
    issue(1, 0, 1, 4'hF, 32'h40, 32'hFFFFFFFF);
    check("oor_wr_err", err1, 1);
    check("oor_wr_valid", v1, 0);
    issue(1, 1, 0, 4'h0, 32'h00, 0);
    check("oor_no_alias", dout1, 32'h0);

    issue(1, 1, 0, 4'h0, 32'h0B, 0);
    check("offset_ignored", dout1, 32'hDEADBEAA);
    issue(1, 0, 1, 4'h0, 32'h08, 32'h0);
    issue(1, 1, 0, 4'h0, 32'h08, 0);
    check("be_zero", dout1, 32'hDEADBEAA);
    issue(0, 1, 1, 4'hF, 32'h08, 32'h0);
    check("cs0_valid", v1, 0);
    check("cs0_err", err1, 0);
    issue(1, 0, 0, 4'hF, 32'h40, 32'h0);
    check("noop_err", err1, 0);
    issue(1, 1, 0, 4'h0, 32'h08, 0);
    check("cs0_no_write", dout1, 32'hDEADBEAA);

    issue(1, 0, 1, 4'hF, 32'h04, 32'h0404CAFE);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 4'h0, pa[i], 0);
      tick();
      check("pipe_lat1_valid", v1, 1);
      check("pipe_lat1_dout", dout1, pe[i]);
      if (i == 0) begin
        check("pipe_lat2_first", v2, 0);
      end else begin
        check("pipe_lat2_valid", v2, 1);
        check("pipe_lat2_dout", dout2, pe[i-1]);
      end
    end
    idle();
    tick();
    check("pipe_lat2_last_valid", v2, 1);
    check("pipe_lat2_last_dout", dout2, pe[2]);
    tick();
    check("pipe_lat2_end", v2, 0);

    rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout1, 0);
    check("async_rst_busy", busy1, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_sweep_busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy1, 1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    issue(1, 1, 0, 4'h0, 32'h08, 0);
    check("busy_req_err", err1, 1);
    check("busy_req_valid", v1, 0);
    check("busy_req_busy", busy1, 1);
    tick();
    check("busy_req_lat2_err", err2, 1);
    check("busy_req_lat2_valid", v2, 0);
    count_busy(n);
    check("resweep_len", 4 + n, 16);
    issue(1, 1, 0, 4'h0, 32'h08, 0);
    check("resweep_cleared", dout1, 32'h0);
    issue(1, 1, 0, 4'h0, 32'h10, 0);
    check("resweep_cleared2", dout1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
